// File: rtl/seq_detect_param_pkg.sv
// rtl/seq_detect_param_pkg.sv - shared constants and elaboration-time pattern functions
package seq_pkg;

  localparam bit OVERLAP_ON  = 1'b1;
  localparam bit OVERLAP_OFF = 1'b0;

  // Prefix bit i (0 = first bit received) of a pattern stored MSB-first in len bits.
  function automatic logic pat_bit(input logic [15:0] pattern, input int len, input int i);
    logic [15:0] s;
    s = pattern >> (len - 1 - i);
    return s[0];
  endfunction

  // Longest proper prefix of the first k pattern bits that is also a suffix of them.
  function automatic int seq_fail(input logic [15:0] pattern, input int len, input int k);
    bit ok;
    for (int j = k - 1; j > 0; j--) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++)
        if (pat_bit(pattern, len, i) != pat_bit(pattern, len, k - j + i))
          ok = 1'b0;
      if (ok)
        return j;
    end
    return 0;
  endfunction

  // Prefix length reached after seeing bit b in state k; len means a full match.
  function automatic int seq_next(input logic [15:0] pattern, input int len, input int k,
                                  input logic b);
    int j;
    j = k;
    while (j > 0 && pat_bit(pattern, len, j) != b)
      j = seq_fail(pattern, len, j);
    if (pat_bit(pattern, len, j) == b)
      return j + 1;
    return 0;
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// rtl/seq_detect_param_if.sv - serial input, controls and status outputs of the detector
interface seq_detect_param_if #(
  parameter int CNT_W = 8,
  parameter int ST_W  = 3
);
  logic             din;
  logic             clr;
  logic             tick;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic [ST_W-1:0]  state;

  modport master (output din, clr, input tick, match, match_cnt, state);
  modport slave  (input din, clr, output tick, match, match_cnt, state);
endinterface

// File: rtl/seq_detect_param_tick_gen.sv
// rtl/seq_detect_param_tick_gen.sv - sample strobe, one clk wide every 2^DIV_W cycles
module tick_gen #(
  parameter int DIV_W = 28
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  if (DIV_W == 0) begin : g_always
    assign tick = ~rst;
  end else begin : g_div
    logic [DIV_W-1:0] div_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        div_q <= '0;
      else
        div_q <= div_q + DIV_W'(1);
    end

    assign tick = &div_q;
  end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised KMP serial pattern detector with match counter
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int             PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10101,
  parameter bit             OVERLAP = OVERLAP_ON,
  parameter int             DIV_W   = 28,
  parameter int             CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_detect_param_if.slave bus
);

  localparam int          ST_W  = $clog2(PAT_W);
  localparam logic [15:0] PAT16 = 16'(PATTERN);

  logic             tick;
  logic [ST_W-1:0]  state_q, state_d;
  logic             hit;
  logic             match_q;
  logic [CNT_W-1:0] cnt_q;

  logic [ST_W-1:0]  nxt_tab [PAT_W][2];
  logic             hit_tab [PAT_W][2];

  tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Transition table is fully constant; a full match folds back to fail(PAT_W) or 0.
  for (genvar k = 0; k < PAT_W; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int RAW = seq_next(PAT16, PAT_W, k, (b == 1));
      localparam int NXT = (RAW == PAT_W) ? (OVERLAP ? seq_fail(PAT16, PAT_W, PAT_W) : 0)
                                          : RAW;
      assign nxt_tab[k][b] = ST_W'(NXT);
      assign hit_tab[k][b] = (RAW == PAT_W);
    end
  end

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (tick) begin
      state_d = nxt_tab[state_q][bus.din];
      hit     = hit_tab[state_q][bus.din];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      match_q <= hit;
      if (bus.clr)
        cnt_q <= '0;
      else if (hit && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.tick      = tick;
  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.state     = state_q;

endmodule
